load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Initiator for the single-cycle datapath's word-indexed data memory.
- Accepts byte/half/word load and store requests from the core via a valid/ready handshake.
- Converts each request into MemRead/MemWrite cycles on the memory port; sub-word stores use read-modify-write.
- Returns the load data, or an error flag, as a one-cycle response pulse.

Parameters:
DEPTH_WORDS, 65, number of 32-bit words in the data memory; word index >= DEPTH_WORDS is out of range

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit idle and able to accept
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  input  1  sign-extend sub-word loads
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result (0 for stores/errors)
resp_err  output  1  misaligned, illegal size, or out-of-range
Address  output  32  word index to memory, {2'b0, req_addr[31:2]}
Writedata  output  32  merged word to memory
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
Readdata  input  32  memory read data

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=0 while in reset, 1 after release; all other outputs 0. Takes effect immediately mid-transaction: MemRead/MemWrite drop at once, transaction abandoned, no response.
- States: IDLE, RD, LATCH, WR, RESP.
- IDLE: req_ready=1. On req_valid, capture all req_* fields and run the error check. req_ready=0 in every other state.
- Error check:
  - size=11 -> error;
  - half with addr[0]=1 -> error;
  - word with addr[1:0]!=0 -> error;
  - addr[31:2] >= DEPTH_WORDS -> error.
- From IDLE on accept:
  - error -> RESP with resp_err=1 (no memory strobe at all);
  - word store -> WR;
  - any load or sub-word store -> RD.
- RD: MemRead=1.
- LATCH: MemRead=1 still; Readdata registered at the end of LATCH. Then load -> RESP; sub-word store -> WR.
- WR: MemRead=0, MemWrite=1, Writedata = merged word. Then -> RESP.
- RESP: resp_valid=1 for exactly one cycle, then -> IDLE. No back-pressure on responses.
- Memory port rules:
  - Address stable from RD/WR entry until RESP.
  - MemRead and MemWrite never both 1.
  - Writedata=0 outside WR.
  - Strobes 0 in IDLE and RESP.
- Lane rules (little-endian):
  - Byte lane = addr[1:0], byte 0 = bits 7:0. Half lane = addr[1], half 0 = bits 15:0.
  - Loads: extract the lane, then zero- or sign-extend per req_signed.
  - Stores: replace only the addressed lane of the read word with req_wdata[7:0] or [15:0]; other bytes unchanged.
- Latency from accept cycle to resp_valid:
  - error: 1 cycle;
  - word store: 2 cycles;
  - load: 3 cycles;
  - sub-word store: 4 cycles.
- Back-to-back: next request is accepted in the IDLE cycle after RESP; minimum spacing = latency+1.
- req_valid deasserting mid-transaction has no effect; fields were captured at accept.

Decomposition:
- Shared package lsu_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state enum;
  - default DEPTH_WORDS=65.
- One sub-module, lsu_lane_align (combinational):
  - load extract/extend: addr[1:0], size, signed, word -> result;
  - store merge: addr[1:0], size, old word, wdata -> new word.
- The FSM stays in load_store_unit.

Test Plan:
- Memory word5=100, load word addr 0x14 -> MemRead high 2 cycles at Address=5; resp_valid 3 cycles after accept; resp_rdata=100, resp_err=0.
- Memory word1=0x00000020, store byte 0xAB to addr 0x05 -> RD, LATCH, then WR with Writedata=0x0000AB20; memory word1=0x0000AB20; resp at cycle 4.
- Memory word2=0x80FF0000, load half signed addr 0x0A -> 0xFFFF80FF; unsigned -> 0x000080FF; signed byte addr 0x0B -> 0xFFFFFF80.
- Load word addr 0x06, and separately addr 0x104 (index 65) -> resp_err=1 one cycle after accept; MemRead/MemWrite never asserted; resp_rdata=0.
- Store half 0x1234 to addr 0x04, rst_n pulsed low during LATCH -> MemRead drops immediately; MemWrite never asserted; memory word1 unchanged; no resp_valid; req_ready=1 after release.
- Word store 0xDEADBEEF to addr 0x00, then a load from the same address issued the cycle req_ready returns -> store completes in 2 cycles; load returns 0xDEADBEEF.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

  localparam int unsigned DEPTH_WORDS_DEFAULT = 65;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StLatch,
    StWr,
    StResp
  } lsu_state_e;

  // Flags illegal size, misalignment and word index past the end of memory.
  function automatic logic req_err(logic [1:0] size, logic [31:0] addr, int unsigned depth);
    logic err;
    err = 1'b0;
    if (size == 2'b11) err = 1'b1;
    if (size == SZ_HALF && addr[0]) err = 1'b1;
    if (size == SZ_WORD && addr[1:0] != 2'b00) err = 1'b1;
    if ({2'b00, addr[31:2]} >= depth) err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extraction for loads and lane merge for stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        is_signed_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Load path: pick the addressed lane, then zero- or sign-extend it.
  always_comb begin
    ld_byte   = rword_i[{addr_lo_i, 3'b000} +: 8];
    ld_half   = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    ld_data_o = 32'h0;
    case (size_i)
      SZ_BYTE: ld_data_o = {{24{is_signed_i & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data_o = {{16{is_signed_i & ld_half[15]}}, ld_half};
      SZ_WORD: ld_data_o = rword_i;
      default: ld_data_o = 32'h0;
    endcase
  end

  // Store path: overwrite only the addressed lane of the old word.
  always_comb begin
    st_word_o = rword_i;
    case (size_i)
      SZ_BYTE: st_word_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      SZ_HALF: begin
        if (addr_lo_i[1]) st_word_o[31:16] = wdata_i[15:0];
        else              st_word_o[15:0]  = wdata_i[15:0];
      end
      SZ_WORD: st_word_o = wdata_i;
      default: st_word_o = rword_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-indexed data memory with read-modify-write sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] Address,
  output logic [31:0] Writedata,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] Readdata
);

  lsu_state_e  state_q, state_d;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic        accept;
  logic        in_err;
  logic [31:0] ld_data;
  logic [31:0] st_word;

  assign accept = (state_q == StIdle) && req_valid;
  assign in_err = req_err(req_size, req_addr, DEPTH_WORDS);

  lsu_lane_align u_lane_align (
    .addr_lo_i   (addr_q[1:0]),
    .size_i      (size_q),
    .is_signed_i (signed_q),
    .rword_i     (rdata_q),
    .wdata_i     (wdata_q),
    .ld_data_o   (ld_data),
    .st_word_o   (st_word)
  );

  // State register; async reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Request capture at accept and read-word capture at the end of LATCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      if (accept) begin
        write_q  <= req_write;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err_q    <= in_err;
      end
      if (state_q == StLatch) rdata_q <= Readdata;
    end
  end

  // Next-state logic: word stores skip the read; errors go straight to the response.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (in_err)                              state_d = StResp;
          else if (req_write && req_size == SZ_WORD) state_d = StWr;
          else                                     state_d = StRd;
        end
      end
      StRd:    state_d = StLatch;
      StLatch: state_d = write_q ? StWr : StResp;
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory port and response outputs decoded from the current state.
  always_comb begin
    req_ready  = rst_n && (state_q == StIdle);
    Address    = 32'h0;
    Writedata  = 32'h0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    if (state_q != StIdle) Address = {2'b00, addr_q[31:2]};
    unique case (state_q)
      StRd, StLatch: MemRead = 1'b1;
      StWr: begin
        MemWrite  = 1'b1;
        Writedata = st_word;
      end
      StResp: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!write_q && !err_q) resp_rdata = ld_data;
      end
      default: ;
    endcase
  end

endmodule
